instr_loader: RTL and testbench

Serial instruction loader that sits directly upstream of the ALU's instruction FIFO. It takes a byte stream from a UART receiver and checks the framing of each 3-byte instruction frame. Each valid frame is packed into the 15-bit word {control, A, B} that the FIFO and the split stage consume. A 2-entry output buffer absorbs FIFO back-pressure, and framing errors and drops are counted for debug LEDs.

---
 rtl/instr_loader.sv | 194 +++++++++++++++++++
 tb/tb_instr_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: frames a UART byte stream into 15-bit ALU instruction words.
//
// A 3-byte frame {header, A, B} is checked for tag order by a small FSM. Each
// complete frame is packed into {control, A, B} and pushed into a 2-entry
// output buffer whose head drives the instruction FIFO write port.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_rx_valid       one-cycle strobe qualifying i_rx_byte
//   i_rx_byte[7:0]   received byte
//   i_fifo_full      downstream FIFO full; suppresses o_wr_en
//   o_data_out[14:0] buffer head word: [14:12]=control, [11:6]=A, [5:0]=B
//   o_wr_en          FIFO write strobe (buffer non-empty and FIFO not full)
//   o_buf_count[1:0] output buffer occupancy, 0..2
//   o_frame_err_cnt  framing error count, saturating at 15
//   o_drop_flag      sticky: a complete word was lost to a full buffer
module instr_loader (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_fifo_full,
    output logic [14:0] o_data_out,
    output logic        o_wr_en,
    output logic [1:0]  o_buf_count,
    output logic [3:0]  o_frame_err_cnt,
    output logic        o_drop_flag
);

    localparam int unsigned CTRL_W = 3;
    localparam int unsigned OPND_W = 6;
    localparam int unsigned WORD_W = CTRL_W + 2 * OPND_W;
    localparam int unsigned OCC_W  = 2;
    localparam int unsigned ERR_W  = 4;

    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(15);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_OP = 2'd1,
        GOT_A  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [CTRL_W-1:0]   w_ctrl_nxt;
    logic [OPND_W-1:0]   r_a;
    logic [OPND_W-1:0]   w_a_nxt;
    logic                w_err;
    logic                w_push;
    logic [WORD_W-1:0]   w_word;

    logic                w_is_hdr;
    logic                w_is_a;
    logic                w_is_b;

    logic [WORD_W-1:0]   r_slot0;
    logic [WORD_W-1:0]   r_slot1;
    logic [OCC_W-1:0]    r_count;
    logic [ERR_W-1:0]    r_err_cnt;
    logic                r_drop;
    logic                w_pop;

    // Byte tag classification
    assign w_is_hdr = i_rx_byte[7];
    assign w_is_a   = (i_rx_byte[7:6] == 2'b00);
    assign w_is_b   = (i_rx_byte[7:6] == 2'b01);
    assign w_word   = {r_ctrl, r_a, i_rx_byte[OPND_W-1:0]};

    // FSM state and field latches
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_ctrl  <= '0;
            r_a     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_a     <= w_a_nxt;
        end
    end

    // Frame parser: next state, latch updates, error and push strobes
    always_comb begin
        w_state_nxt = r_state;
        w_ctrl_nxt  = r_ctrl;
        w_a_nxt     = r_a;
        w_err       = 1'b0;
        w_push      = 1'b0;
        if (i_rx_valid) begin
            case (r_state)
                IDLE: begin
                    if (w_is_hdr) begin
                        w_ctrl_nxt  = i_rx_byte[CTRL_W-1:0];
                        w_state_nxt = GOT_OP;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                GOT_OP: begin
                    if (w_is_a) begin
                        w_a_nxt     = i_rx_byte[OPND_W-1:0];
                        w_state_nxt = GOT_A;
                    end else if (w_is_hdr) begin
                        // A fresh header restarts the frame with its control
                        w_err      = 1'b1;
                        w_ctrl_nxt = i_rx_byte[CTRL_W-1:0];
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                GOT_A: begin
                    if (w_is_b) begin
                        w_push      = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (w_is_hdr) begin
                        w_err       = 1'b1;
                        w_ctrl_nxt  = i_rx_byte[CTRL_W-1:0];
                        w_state_nxt = GOT_OP;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // FIFO write is offered whenever a word is buffered and the FIFO has room
    assign w_pop   = (r_count != '0) && !i_fifo_full;
    assign o_wr_en = w_pop;

    // Two-slot shift buffer; slot0 is always the head so data_out is a flop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_count <= '0;
            r_drop  <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    // Pop frees a slot first, so occupancy is unchanged
                    if (r_count == OCC_W'(2)) begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= w_word;
                    end else begin
                        r_slot0 <= w_word;
                    end
                end
                2'b01: begin
                    if (r_count == OCC_W'(2)) begin
                        r_slot0 <= r_slot1;
                    end
                    r_count <= r_count - OCC_W'(1);
                end
                2'b10: begin
                    if (r_count == OCC_W'(0)) begin
                        r_slot0 <= w_word;
                        r_count <= OCC_W'(1);
                    end else if (r_count == OCC_W'(1)) begin
                        r_slot1 <= w_word;
                        r_count <= OCC_W'(2);
                    end else begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating framing error counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != ERR_MAX)) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign o_data_out      = r_slot0;
    assign o_buf_count     = r_count;
    assign o_frame_err_cnt = r_err_cnt;
    assign o_drop_flag     = r_drop;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed scenarios plus random byte streams,
// compared every cycle against a queue-based frame model.
module tb_instr_loader;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        fifo_full;
    logic [14:0] data_out;
    logic        wr_en;
    logic [1:0]  buf_count;
    logic [3:0]  frame_err_cnt;
    logic        drop_flag;

    instr_loader dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_rx_valid      (rx_valid),
        .i_rx_byte       (rx_byte),
        .i_fifo_full     (fifo_full),
        .o_data_out      (data_out),
        .o_wr_en         (wr_en),
        .o_buf_count     (buf_count),
        .o_frame_err_cnt (frame_err_cnt),
        .o_drop_flag     (drop_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: pending control/A (-1 = absent), queue of buffered words
    int          m_ctrl = -1;
    int          m_a    = -1;
    int          m_err  = 0;
    bit          m_drop = 1'b0;
    logic [14:0] m_q[$];

    // Values seen on the DUT during the most recent step
    logic [14:0] s_data;
    logic        s_wr;
    logic [1:0]  s_cnt;
    logic [3:0]  s_err;
    logic        s_drop;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = -1;
        m_a    = -1;
        m_err  = 0;
        m_drop = 1'b0;
        m_q.delete();
    endtask

    task automatic model_err();
        if (m_err < 15) m_err++;
    endtask

    // Apply one rx byte to the frame model
    task automatic model_byte(input logic [7:0] b);
        if (b[7]) begin
            if (m_ctrl != -1) model_err();
            m_ctrl = int'(b[2:0]);
            m_a    = -1;
        end else if (b[7:6] == 2'b00 && m_ctrl != -1 && m_a == -1) begin
            m_a = int'(b[5:0]);
        end else if (b[7:6] == 2'b01 && m_a != -1) begin
            logic [14:0] w;
            w = {3'(m_ctrl), 6'(m_a), b[5:0]};
            if (m_q.size() < 2) m_q.push_back(w);
            else m_drop = 1'b1;
            m_ctrl = -1;
            m_a    = -1;
        end else begin
            model_err();
            m_ctrl = -1;
            m_a    = -1;
        end
    endtask

    // One clock cycle: drive, compare against model, then advance the model
    task automatic step(input bit v, input logic [7:0] b, input bit ff);
        bit exp_wr;
        @(negedge clk);
        rx_valid  = v;
        rx_byte   = b;
        fifo_full = ff;
        #1;
        s_data = data_out;
        s_wr   = wr_en;
        s_cnt  = buf_count;
        s_err  = frame_err_cnt;
        s_drop = drop_flag;
        exp_wr = (m_q.size() != 0) && !ff;
        chk("wr_en", 32'(wr_en), 32'(exp_wr));
        chk("buf_count", 32'(buf_count), 32'(m_q.size()));
        chk("frame_err_cnt", 32'(frame_err_cnt), 32'(m_err));
        chk("drop_flag", 32'(drop_flag), 32'(m_drop));
        if (m_q.size() != 0) chk("data_out", 32'(data_out), 32'(m_q[0]));
        if (exp_wr) void'(m_q.pop_front());
        if (v) model_byte(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_buf_count", 32'(buf_count), 32'h0);
        chk("rst_err_cnt", 32'(frame_err_cnt), 32'h0);
        chk("rst_drop", 32'(drop_flag), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic frame(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b, input bit ff);
        step(1'b1, h, ff);
        step(1'b1, a, ff);
        step(1'b1, b, ff);
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Basic frame
        frame(8'h85, 8'h2A, 8'h53, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("basic_wr", 32'(s_wr), 32'h1);
        chk("basic_word", 32'(s_data), 32'h5A93);
        chk("basic_err", 32'(s_err), 32'h0);
        step(1'b0, 8'h00, 1'b0);
        chk("basic_single_pulse", 32'(s_wr), 32'h0);

        // Back-pressure with a dropped third frame
        do_reset();
        frame(8'h81, 8'h01, 8'h41, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("bp_cnt1", 32'(s_cnt), 32'h1);
        frame(8'h82, 8'h02, 8'h42, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("bp_cnt2", 32'(s_cnt), 32'h2);
        frame(8'h83, 8'h03, 8'h43, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("bp_cnt3", 32'(s_cnt), 32'h2);
        chk("bp_drop", 32'(s_drop), 32'h1);
        step(1'b0, 8'h00, 1'b0);
        chk("bp_pop1_wr", 32'(s_wr), 32'h1);
        chk("bp_pop1_word", 32'(s_data), 32'h1041);
        step(1'b0, 8'h00, 1'b0);
        chk("bp_pop2_wr", 32'(s_wr), 32'h1);
        chk("bp_pop2_word", 32'(s_data), 32'h2082);
        step(1'b0, 8'h00, 1'b0);
        chk("bp_no_third", 32'(s_wr), 32'h0);

        // Resync on repeated header
        do_reset();
        step(1'b1, 8'h81, 1'b0);
        frame(8'h81, 8'h05, 8'h41, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("resync_err", 32'(s_err), 32'h1);
        chk("resync_wr", 32'(s_wr), 32'h1);
        chk("resync_word", 32'(s_data), 32'h1141);

        // Error counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'hC0, 1'b0);
            step(1'b1, 8'h80, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0);
        chk("sat_err", 32'(s_err), 32'hF);

        // Lone B-tag byte in IDLE, then a normal frame
        do_reset();
        step(1'b1, 8'h40, 1'b0);
        frame(8'h85, 8'h2A, 8'h53, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("lone_err", 32'(s_err), 32'h1);
        chk("lone_word", 32'(s_data), 32'h5A93);
        chk("lone_wr", 32'(s_wr), 32'h1);

        // Push and pop together at full occupancy
        do_reset();
        frame(8'h81, 8'h01, 8'h41, 1'b1);
        frame(8'h82, 8'h02, 8'h42, 1'b1);
        step(1'b1, 8'h83, 1'b1);
        step(1'b1, 8'h03, 1'b1);
        step(1'b1, 8'h43, 1'b0);
        chk("pp_wr", 32'(s_wr), 32'h1);
        chk("pp_head", 32'(s_data), 32'h1041);
        step(1'b0, 8'h00, 1'b1);
        chk("pp_cnt", 32'(s_cnt), 32'h2);
        chk("pp_drop", 32'(s_drop), 32'h0);
        step(1'b0, 8'h00, 1'b0);
        chk("pp_w2", 32'(s_data), 32'h2082);
        step(1'b0, 8'h00, 1'b0);
        chk("pp_w3", 32'(s_data), 32'h30C3);
        chk("pp_w3_wr", 32'(s_wr), 32'h1);

        // Reset mid-frame with a buffered word
        do_reset();
        frame(8'h81, 8'h01, 8'h41, 1'b1);
        step(1'b1, 8'h82, 1'b1);
        step(1'b1, 8'h02, 1'b1);
        do_reset();
        frame(8'h85, 8'h2A, 8'h53, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("mid_rst_wr", 32'(s_wr), 32'h1);
        chk("mid_rst_word", 32'(s_data), 32'h5A93);
        chk("mid_rst_cnt", 32'(s_cnt), 32'h1);
        step(1'b0, 8'h00, 1'b0);
        chk("mid_rst_once", 32'(s_wr), 32'h0);

        // Random traffic, mostly well-formed frames
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] b;
            int unsigned r;
            int unsigned slot;
            r    = $urandom_range(0, 99);
            slot = i % 3;
            b    = 8'($urandom);
            if (r < 80) begin
                if (slot == 0) b[7] = 1'b1;
                else if (slot == 1) b[7:6] = 2'b00;
                else b[7:6] = 2'b01;
            end
            if (i % 997 == 500) do_reset();
            step(1'($urandom_range(0, 3) != 0), b, 1'($urandom_range(0, 2) == 0));
        end
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
